// File: rtl/mod_pkg.sv
// -----------------------------------------------------------------------------
// mod_pkg
// Shared types and constants for the modulo arbiter slice.
//   state_t     : arbiter FSM encoding (IDLE / RUN / DONE)
//   WIDTH_DEF   : default operand/result width
//   NUM_REQ_DEF : default requester count
//   CNT_W/IDX_W : counter and index widths for the default configuration
//   clog2_min1  : $clog2 clamped to at least 1 bit, for parameterized widths
// -----------------------------------------------------------------------------
package mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF   = 32;
    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W       = $clog2(WIDTH_DEF);
    localparam int IDX_W       = $clog2(NUM_REQ_DEF);

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mod_arbiter_if.sv
// -----------------------------------------------------------------------------
// mod_arbiter_if
// Request/response bus between the clients and the modulo arbiter.
//   req      : per-requester request level
//   a_in     : dividends, requester i at [i*WIDTH +: WIDTH]
//   b_in     : divisors, same packing
//   ack      : one-hot pulse, operands of that requester accepted
//   done     : one-hot pulse, result valid for that requester
//   result   : a mod b of the last completed operation
//   div_zero : qualifies result at done, set when b was 0
//   busy     : high from acceptance until the cycle after done
// Modports: master = client side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mod_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       done;
    logic [WIDTH-1:0]         result;
    logic                     div_zero;
    logic                     busy;

    modport master (
        output req, a_in, b_in,
        input  ack, done, result, div_zero, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output ack, done, result, div_zero, busy
    );
endinterface

// File: rtl/mod_engine.sv
// -----------------------------------------------------------------------------
// mod_engine
// Iterative shift-subtract remainder unit, one dividend bit per cycle, MSB
// first, WIDTH iterations per operation.
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b, clear remainder, begin iterating
//   a, b       : dividend / divisor (b must be non-zero)
//   rem_out    : remainder after the current iteration (combinational)
//   fin        : high during the final iteration; rem_out is the answer
// -----------------------------------------------------------------------------
module mod_engine
    import mod_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem_out,
    output logic             fin
);
    localparam int CW = clog2_min1(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             running;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // rem < b always holds, so the shifted trial value fits in WIDTH+1 bits
    // and the reduced result fits back into WIDTH bits.
    always_comb begin
        trial   = {rem, a_q[cnt]};
        diff    = trial - {1'b0, b_q};
        rem_out = (trial >= {1'b0, b_q}) ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        fin     = running && (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            rem     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_q     <= a;
            b_q     <= b;
            rem     <= '0;
            cnt     <= CW'(WIDTH - 1);
            running <= 1'b1;
        end else if (running) begin
            rem <= rem_out;
            cnt <= cnt - 1'b1;
            if (cnt == '0)
                running <= 1'b0;
        end
    end
endmodule

// File: rtl/mod_arbiter.sv
// -----------------------------------------------------------------------------
// mod_arbiter
// Round-robin front end for a single shared modulo engine.
//   clk   : system clock, rising edge
//   reset : async active-low reset, aborts any operation in flight
//   bus   : mod_arbiter_if.slave (req/a_in/b_in in, ack/done/result/
//           div_zero/busy out)
// A winner is picked in IDLE searching upward from the pointer; its operands
// go to mod_engine, and the remainder comes back with a one-cycle done pulse.
// b==0 completes immediately with result=a, div_zero=1.
// Optional build macro MOD_FAST_PATH_EN: a<=b also completes immediately
// (a<b gives a, a==b gives 0); without it latency is always WIDTH+1.
// -----------------------------------------------------------------------------
module mod_arbiter
    import mod_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mod_arbiter_if.slave bus
);
    localparam int IW = clog2_min1(NUM_REQ);

    state_t             state, state_nxt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      win;
    logic [IW-1:0]      j;
    logic               any_req;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               take_dz, take_fast, accept;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] done_c;
    logic               busy_c;
    logic [WIDTH-1:0]   result_q;
    logic               dz_q;
    logic               eng_start, eng_fin;
    logic [WIDTH-1:0]   eng_rem;

    // Round-robin pick: first set request at or above the pointer, wrapping.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        j       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            if (!any_req && bus.req[j]) begin
                any_req = 1'b1;
                win     = j;
            end
        end
        a_sel = bus.a_in[int'(win)*WIDTH +: WIDTH];
        b_sel = bus.b_in[int'(win)*WIDTH +: WIDTH];
    end

    assign take_dz = (b_sel == '0);
`ifdef MOD_FAST_PATH_EN
    assign take_fast = (a_sel <= b_sel);
`else
    assign take_fast = 1'b0;
`endif
    assign accept    = (state == IDLE) && any_req;
    assign eng_start = accept && !take_dz && !take_fast;

    mod_engine #(.WIDTH(WIDTH)) u_engine (
        .clk     (clk),
        .rst_n   (reset),
        .start   (eng_start),
        .a       (a_sel),
        .b       (b_sel),
        .rem_out (eng_rem),
        .fin     (eng_fin)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = (take_dz || take_fast) ? DONE : RUN;
            RUN:  if (eng_fin) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        done_c = '0;
        busy_c = (state != IDLE);
        if (state == DONE)
            done_c = NUM_REQ'(1) << idx;
    end

    // Datapath: winner index, pointer, ack pulse, held result.
    // result_q is loaded on the edge entering DONE so it is valid with done
    // and stays put until the next completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            idx      <= '0;
            ack_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            ack_q <= '0;
            if (accept) begin
                idx   <= win;
                ack_q <= NUM_REQ'(1) << win;
                if (take_dz) begin
                    result_q <= a_sel;
                    dz_q     <= 1'b1;
                end else if (take_fast) begin
                    result_q <= (a_sel == b_sel) ? '0 : a_sel;
                    dz_q     <= 1'b0;
                end
            end
            if (state == RUN && eng_fin) begin
                result_q <= eng_rem;
                dz_q     <= 1'b0;
            end
            if (state == DONE)
                ptr <= IW'((int'(idx) + 1) % NUM_REQ);
        end
    end

    assign bus.ack      = ack_q;
    assign bus.done     = done_c;
    assign bus.busy     = busy_c;
    assign bus.result   = result_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mod_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mod_arbiter
// Directed stimulus pushes the expected ack index and completion record into
// queues; a monitor on the falling edge pops and compares whenever ack or done
// is presented. Latency is measured from the ack cycle to the done cycle.
// -----------------------------------------------------------------------------
module tb_mod_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
`ifdef MOD_FAST_PATH_EN
    localparam int FLAT = 0;
`else
    localparam int FLAT = W;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mod_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    mod_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t done_q[$];
    int   ack_q[$];
    int   ack_cyc[NR];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ack != '0) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got %b expected none", bus.ack);
                end else begin
                    int i;
                    i = ack_q.pop_front();
                    chk("ack_onehot", 64'(bus.ack), 64'(1) << i);
                    ack_cyc[i] = cyc;
                end
            end
            if (bus.done != '0) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got %b expected none", bus.done);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    chk("done_onehot", 64'(bus.done), 64'(1) << e.idx);
                    chk("result", 64'(bus.result), 64'(e.res));
                    chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
                    chk("latency", 64'(cyc - ack_cyc[e.idx]), 64'(e.lat));
                end
            end
        end
    end

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic dz, input int lat);
        exp_t e;
        bus.a_in[i*W +: W] = a;
        bus.b_in[i*W +: W] = b;
        bus.req[i]         = 1'b1;
        e.idx = i; e.res = res; e.dz = dz; e.lat = lat;
        ack_q.push_back(i);
        done_q.push_back(e);
    endtask

    task automatic wait_ack(input int i, input bit drop);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.ack[i]) begin
                if (drop) bus.req[i] = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL ack_timeout: requester %0d got no ack within 100 cycles", i);
        bus.req[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.done[i]) return;
        end
        checks++; errors++;
        $display("FAIL done_timeout: requester %0d got no done within 100 cycles", i);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout: busy still %0b after 200 cycles", bus.busy);
    endtask

    initial begin
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack",      64'(bus.ack),      64'd0);
        chk("rst_done",     64'(bus.done),     64'd0);
        chk("rst_result",   64'(bus.result),   64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous 0101 from pointer 0: 0 first, then 2 (pointer ends at 3)
        issue(0, 100, 7, 2, 1'b0, W);
        issue(2, 9, 4, 1, 1'b0, W);
        wait_ack(0, 1'b1);
        wait_ack(2, 1'b1);
        wait_idle();

        // 0011 with pointer 3: wraps to 0 before 1
        issue(0, 50, 6, 2, 1'b0, W);
        issue(1, 1000, 9, 1, 1'b0, W);
        wait_ack(0, 1'b1);
        wait_ack(1, 1'b1);
        wait_idle();

        // Single request, busy drops the cycle after done
        issue(0, 14, 5, 4, 1'b0, W);
        wait_ack(0, 1'b1);
        wait_done(0);
        chk("busy_at_done", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(bus.busy), 64'd0);

        // Divide by zero
        issue(1, 7, 0, 7, 1'b1, 0);
        wait_ack(1, 1'b1);
        wait_idle();

        // Width boundaries
        issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1'b0, W);
        wait_ack(2, 1'b1);
        wait_idle();
        issue(3, 32'hFFFF_FFFF, 1, 0, 1'b0, W);
        wait_ack(3, 1'b1);
        wait_idle();

        // a == b and a < b (fast-path dependent latency)
        issue(0, 12, 12, 0, 1'b0, FLAT);
        wait_ack(0, 1'b1);
        wait_idle();
        issue(0, 3, 10, 3, 1'b0, FLAT);
        wait_ack(0, 1'b1);
        wait_idle();

        // Reset mid-RUN: aborted op gives no done; held request re-accepted
        issue(3, 14, 5, 4, 1'b0, W);
        ack_q.push_back(3);
        wait_ack(3, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ack",      64'(bus.ack),      64'd0);
        chk("midrst_done",     64'(bus.done),     64'd0);
        chk("midrst_busy",     64'(bus.busy),     64'd0);
        chk("midrst_result",   64'(bus.result),   64'd0);
        chk("midrst_div_zero", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack(3, 1'b1);
        wait_idle();

        chk("ack_queue_empty",  64'(ack_q.size()),  64'd0);
        chk("done_queue_empty", 64'(done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/mod_arbiter.md
Name: mod_arbiter

Overview:
- Shares a single iterative 32-bit modulo datapath between NUM_REQ requesters.
- Round-robin arbitration; the winner's operands are latched and a shift-subtract remainder is computed over WIDTH cycles.
- The result is returned to the winner with a one-cycle done pulse.
- Sits between the ALU/accelerator clients and the modulo engine; it is the only path into the engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  NUM_REQ  per-requester request level.
- a_in  input  NUM_REQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH].
- b_in  input  NUM_REQ*WIDTH  divisors, same packing.
- ack  output  NUM_REQ  one-hot, one-cycle pulse: operands of that requester accepted.
- done  output  NUM_REQ  one-hot, one-cycle pulse: result valid for that requester.
- result  output  WIDTH  a mod b of the last completed operation; held stable until the next done.
- div_zero  output  1  qualifies result at done; 1 when b was 0.
- busy  output  1  high from acceptance until the cycle after done.

Behaviour:
- Reset (reset=0), asserted asynchronously:
  - state=IDLE, ack=0, done=0, result=0, div_zero=0, busy=0.
  - Round-robin pointer=0, iteration counter=0.
  - Reset mid-operation aborts the operation; no done is emitted for it.
- FSM states: IDLE, RUN, DONE.
- IDLE, on any req bit set at edge T:
  - Select the first set bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - Latch a, b and the index.
  - ack[idx]=1 during cycle T+1 only; busy=1.
  - If b==0: next state DONE, result=a, div_zero=1.
  - Otherwise: next state RUN, counter=WIDTH-1, partial remainder=0.
- RUN, each cycle:
  - rem' = {rem, a[counter]}; if rem' >= b then rem' -= b.
  - The comparison uses a WIDTH+1-bit intermediate so it never overflows.
  - Counter decrements. After the iteration with counter==0, go to DONE.
  - Exactly WIDTH RUN cycles.
- DONE, one cycle:
  - done[idx]=1; result=remainder (registered, visible this cycle); div_zero as latched.
  - Pointer=(idx+1) mod NUM_REQ. Next state IDLE.
  - busy drops in the following cycle.
- Latency:
  - Normal operation: done asserted WIDTH+1 cycles after the acceptance edge (33 for WIDTH=32).
  - b==0: done 1 cycle after acceptance.
- Back-to-back: a request pending in the cycle after DONE is accepted at that edge. Minimum spacing between acceptances is WIDTH+2 cycles.
- Requester rules:
  - Hold req and operands stable until ack.
  - req still high after ack counts as a new request.
  - req changes while not in IDLE are ignored.
- Simultaneous requests: exactly one ack per acceptance. Losers wait; no starvation (each waits at most NUM_REQ-1 operations).
- a < b takes the full WIDTH cycles unless the optional feature is enabled.

Optional Feature:
- MOD_FAST_PATH_EN
- Defined:
  - At acceptance, if b!=0 and a<b, skip RUN and go to DONE with result=a, div_zero=0. Latency is 1 cycle.
  - If a==b, result=0 with latency 1.
- Undefined: every b!=0 operation takes WIDTH+1 cycles (deterministic latency).

Decomposition:
- Package mod_pkg:
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH.
  - Counter width localparam CNT_W=$clog2(WIDTH).
  - Index width localparam IDX_W=$clog2(NUM_REQ).
- Sub-module mod_engine:
  - Shift-subtract remainder unit with start/a/b inputs and rem_out/fin outputs.
  - Owns the counter and partial remainder.
- The arbiter keeps the FSM, pointer, operand mux and output registers.

Test Plan:
- Single request, requester 0, a=14, b=5:
  - ack[0] at T+1.
  - done[0] at T+33 with result=4, div_zero=0.
  - busy low at T+34.
- req=4'b0101 simultaneously, (a,b)=(100,7) and (9,4):
  - Requester 0 served first, result 2.
  - Then requester 2, result 1.
  - Then req=4'b0011 with pointer=3: requester 0 granted before 1.
- Divide by zero, requester 1, a=7, b=0:
  - done[1] one cycle after acceptance, result=7, div_zero=1.
- Width boundary, a=32'hFFFFFFFF, b=32'hFFFFFFFE:
  - result=1.
  - a=32'hFFFFFFFF, b=1 gives result=0.
- Reset mid-RUN (reset=0 for 2 cycles at T+10):
  - All outputs 0 immediately; no done pulse.
  - The held request is re-accepted after release and completes correctly.
- With MOD_FAST_PATH_EN, a=3, b=10:
  - done one cycle after acceptance, result=3.
  - Without the macro, the same stimulus gives done at T+33.
